seq_multiplier: RTL and testbench

Multi-cycle shift-add multiplier, the multiply-direction counterpart of the team's shift-subtract divider. It computes one partial product per clock and supports signed and unsigned operands. Valid/ready handshakes on the operand and result sides let the processor datapath issue an operation, stall, and collect a full-width product. It replaces combinational multiply where timing closure matters.

---
 rtl/seq_multiplier_pkg.sv | 29 ++
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier_adder.sv | 16 +
 rtl/seq_multiplier.sv | 117 +++++++++++
 tb/tb_seq_multiplier.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared arithmetic definitions for the sequential multiply/divide units:
// FSM state encoding and the operand magnitude/sign split.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Wide enough for any operand width the datapath units are built with.
  localparam int unsigned MAG_W = 128;
  typedef logic [MAG_W-1:0] mag_t;

  // Magnitude of the low 'width' bits of value; two's-complement negation is
  // applied only for signed operands whose sign bit is set.
  function automatic mag_t abs_mag(input mag_t value, input int unsigned width,
                                   input logic signed_mode);
    mag_t mask;
    mask = '1;
    mask = mask >> (MAG_W - width);
    if (signed_mode && value[width-1]) begin
      return (~value + mag_t'(1)) & mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result valid-ready bundle for seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned SIZE = 32
);
  logic                in_valid;
  logic                in_ready;
  logic                signed_mode;
  logic [SIZE-1:0]     fir_num;
  logic [SIZE-1:0]     sec_num;
  logic                out_valid;
  logic                out_ready;
  logic [2*SIZE-1:0]   product;

  modport master (
    output in_valid, signed_mode, fir_num, sec_num, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, signed_mode, fir_num, sec_num, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_multiplier_adder.sv
// adderNU: N-bit unsigned adder; clk/rst are carried on the port list so it
// drops into the existing datapath wiring, the sum itself is combinational.
module adderNU #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic unused_ctl;

  assign unused_ctl = clk ^ rst;
  assign sum        = a + b;
endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per clock over SIZE clocks,
// signed operands handled by magnitude multiply plus a final sign fix.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);
  localparam int unsigned        CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(SIZE - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE-1:0]     hi_q, hi_d;
  logic [SIZE-1:0]     lo_q, lo_d;
  logic [SIZE-1:0]     mcand_q, mcand_d;
  logic                neg_q, neg_d;
  logic                out_valid_q, out_valid_d;
  logic [2*SIZE-1:0]   product_q, product_d;

  mag_t                fir_abs, sec_abs;
  logic                unused_mag_hi;
  logic [SIZE:0]       add_b, add_sum;
  logic [2*SIZE-1:0]   acc;

  assign fir_abs       = abs_mag(MAG_W'(bus.fir_num), SIZE, bus.signed_mode);
  assign sec_abs       = abs_mag(MAG_W'(bus.sec_num), SIZE, bus.signed_mode);
  assign unused_mag_hi = ^{fir_abs[MAG_W-1:SIZE], sec_abs[MAG_W-1:SIZE]};

  // Low half of the accumulator doubles as the multiplier shift register.
  assign add_b = lo_q[0] ? {1'b0, mcand_q} : '0;
  assign acc   = {hi_q, lo_q};

  adderNU #(
    .N(SIZE + 1)
  ) u_add (
    .clk (clk),
    .rst (rst),
    .a   ({1'b0, hi_q}),
    .b   (add_b),
    .sum (add_sum)
  );

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          hi_d    = '0;
          lo_d    = fir_abs[SIZE-1:0];
          mcand_d = sec_abs[SIZE-1:0];
          neg_d   = bus.signed_mode && (bus.fir_num[SIZE-1] ^ bus.sec_num[SIZE-1]);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // {carry, hi, mplier} >> 1 after the conditional add
        hi_d  = add_sum[SIZE:1];
        lo_d  = {add_sum[0], lo_q[SIZE-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d   = neg_q ? (~acc + (2*SIZE)'(1)) : acc;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at SIZE=8 and SIZE=32: fixed vectors, handshake
// corner sequences and randomized operations against an arithmetic model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  seq_multiplier_if #(.SIZE(8))  if8 ();
  seq_multiplier_if #(.SIZE(32)) if32 ();

  seq_multiplier #(.SIZE(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_multiplier #(.SIZE(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 8) ? if8.out_valid : if32.out_valid;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 8) ? if8.in_ready : if32.in_ready;
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    return (sel == 8) ? 64'(if8.product) : if32.product;
  endfunction

  task automatic drive(input int sel, input logic v, input logic sm,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 8) begin
      if8.in_valid = v; if8.signed_mode = sm; if8.fir_num = a[7:0]; if8.sec_num = b[7:0];
    end else begin
      if32.in_valid = v; if32.signed_mode = sm; if32.fir_num = a; if32.sec_num = b;
    end
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 8) if8.out_ready = r;
    else          if32.out_ready = r;
  endtask

  // Reference: plain integer multiplication, truncated to the product width.
  function automatic logic [63:0] ref_mul(input int sel, input logic sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    if (sel == 8) begin
      sa = sm ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      sb = sm ? longint'($signed(b[7:0])) : longint'(b[7:0]);
      r  = 64'(sa * sb) & 64'hFFFF;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 64'(sa * sb);
    end else begin
      r = {32'b0, a} * {32'b0, b};
    end
    return r;
  endfunction

  task automatic issue(input int sel, input logic sm, input logic [31:0] a, input logic [31:0] b);
    int unsigned n = 0;
    @(negedge clk);
    while (!get_ir(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("issue_in_ready");
    drive(sel, 1'b1, sm, a, b);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic collect(input int sel, input logic [63:0] exp, input string name, input bit rnd);
    bit   done = 1'b0;
    logic rdy;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(sel, rdy);
      if (get_ov(sel) && rdy) begin
        check(name, get_prod(sel), exp);
        done = 1'b1;
      end
    end
    if (!done) begin
      timeout(name);
    end else begin
      @(posedge clk);
      #1 set_ready(sel, 1'b0);
      check({name, "_drained"}, 64'(get_ov(sel)), 64'd0);
    end
  endtask

  initial begin
    bit          seen;
    logic        sm;
    logic [31:0] a, b;
    int          sel;

    vecs[0] = '{8,  1'b0, 32'd200,        32'd255,        64'd51000,               "u8_200x255"};
    vecs[1] = '{8,  1'b1, 32'hFD,         32'h05,         64'hFFF1,                "s8_m3x5"};
    vecs[2] = '{8,  1'b1, 32'h80,         32'h80,         64'h4000,                "s8_m128xm128"};
    vecs[3] = '{8,  1'b1, 32'h80,         32'h7F,         64'hC080,                "s8_m128x127"};
    vecs[4] = '{8,  1'b1, 32'h00,         32'hFF,         64'h0000,                "s8_0xm1"};
    vecs[5] = '{8,  1'b0, 32'hFF,         32'hFF,         64'hFE01,                "u8_255x255"};
    vecs[6] = '{32, 1'b1, 32'h0,          32'hFFFFFFFF,   64'h0,                   "s32_0xm1"};
    vecs[7] = '{32, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001,    "u32_max_sq"};
    vecs[8] = '{32, 1'b1, 32'h80000000,   32'h80000000,   64'h4000000000000000,    "s32_min_sq"};
    vecs[9] = '{32, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h1,                   "s32_m1xm1"};

    drive(8, 1'b0, 1'b0, '0, '0);
    drive(32, 1'b0, 1'b0, '0, '0);
    set_ready(8, 1'b0);
    set_ready(32, 1'b0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready8", 64'(get_ir(8)), 64'd0);
    check("rst_out_valid8", 64'(get_ov(8)), 64'd0);
    check("rst_product8", get_prod(8), 64'd0);
    check("rst_out_valid32", 64'(get_ov(32)), 64'd0);
    check("rst_product32", get_prod(32), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready8", 64'(get_ir(8)), 64'd1);
    check("post_rst_in_ready32", 64'(get_ir(32)), 64'd1);

    // Latency: out_valid rises after accept edge + 9 for SIZE=8
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'd200, 32'd255);
    @(posedge clk);
    #1 drive(8, 1'b0, 1'b1, 32'd3, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check("lat_out_valid", 64'(get_ov(8)), 64'(k == 9));
      check("lat_in_ready", 64'(get_ir(8)), 64'd0);
    end
    check("lat_product", get_prod(8), 64'd51000);
    set_ready(8, 1'b1);
    @(posedge clk);
    #1 set_ready(8, 1'b0);
    check("lat_xfer_out_valid", 64'(get_ov(8)), 64'd0);
    check("lat_xfer_in_ready", 64'(get_ir(8)), 64'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].sel, vecs[i].sm, vecs[i].a, vecs[i].b);
      collect(vecs[i].sel, vecs[i].exp, vecs[i].name, 1'b0);
    end

    // Backpressure with in_valid noise while the result is held
    issue(8, 1'b0, 32'h12, 32'h34);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = get_ov(8);
    end
    if (!seen) timeout("bp_wait_valid");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(8, k[0], k[1], $urandom, $urandom);
      check("bp_product", get_prod(8), 64'h3A8);
      check("bp_out_valid", 64'(get_ov(8)), 64'd1);
      check("bp_in_ready", 64'(get_ir(8)), 64'd0);
    end
    @(negedge clk);
    drive(8, 1'b0, 1'b0, '0, '0);
    set_ready(8, 1'b1);
    @(posedge clk);
    #1 set_ready(8, 1'b0);
    check("bp_xfer_out_valid", 64'(get_ov(8)), 64'd0);
    check("bp_xfer_in_ready", 64'(get_ir(8)), 64'd1);
    check("bp_product_held", get_prod(8), 64'h3A8);
    issue(8, 1'b1, 32'hF9, 32'h0C);
    collect(8, 64'hFFAC, "b2b_m7x12", 1'b0);
    issue(8, 1'b0, 32'hFF, 32'h02);
    collect(8, 64'h01FE, "b2b_255x2", 1'b0);

    // Reset during the 4th CALC iteration
    issue(8, 1'b0, 32'hAB, 32'hCD);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(get_ov(8)), 64'd0);
    check("midrst_product", get_prod(8), 64'd0);
    check("midrst_in_ready", 64'(get_ir(8)), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", 64'(get_ir(8)), 64'd1);
    issue(8, 1'b0, 32'd7, 32'd6);
    collect(8, 64'd42, "midrst_7x6", 1'b0);

    // Randomized operations, both widths and both modes
    for (int i = 0; i < 1300; i++) begin
      sel = (i < 1000) ? 8 : 32;
      sm  = i[0];
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 9) == 0) a = (sel == 8) ? 32'h80 : 32'h80000000;
      if ($urandom_range(0, 9) == 0) b = (sel == 8) ? 32'h80 : 32'h80000000;
      if ($urandom_range(0, 19) == 0) b = '0;
      issue(sel, sm, a, b);
      collect(sel, ref_mul(sel, sm, a, b), (sel == 8) ? "rand8" : "rand32", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
